led_cmd_sequencer: RTL
======================

// Module: led_cmd_sequencer
// PURPOSE
//  Host-side controller for the 19-LED CPLD driver. Queues LED commands (5-bit address, active, pattern),
//  serialises each as one 7-bit frame on SCLK/SDATA, and latches it with an SLATCH pulse.
//  Also generates the shared SPATTERN blink square wave. Sits between the system logic and the CPLD serial pins.
// PARAMETERS
//  LED_TOT    19   number of LEDs; commands with address >= LED_TOT are rejected
//  DEPTH      4    command FIFO depth (power of 2, >= 2)
//  DIV        2    CLK cycles per SCLK half-period (>= 1)
//  BLINK_DIV  4    CLK cycles per SPATTERN half-period (>= 1)
// PORTS
//  CLK          in   1  system clock; all logic is on its rising edge
//  RESET        in   1  synchronous, active-high reset
//  CMD_VALID    in   1  command present
//  CMD_READY    out  1  FIFO not full; a command is accepted when CMD_VALID & CMD_READY
//  CMD_ADDR     in   5  LED address
//  CMD_ACTIVE   in   1  LED steady-on bit
//  CMD_PATTERN  in   1  LED follows-blink bit
//  BLINK_EN     in   1  enable for the SPATTERN generator
//  BUSY         out  1  frame in progress (LOAD through GAP)
//  ERR_ADDR     out  1  one-cycle pulse when a popped command has an illegal address
//  SCLK         out  1  serial clock to the CPLD (registered)
//  SDATA        out  1  serial data (registered)
//  SLATCH       out  1  latch strobe (registered)
//  SPATTERN     out  1  blink signal (registered)
// BEHAVIOUR
//  Reset: FIFO emptied, FSM=IDLE, counters cleared. SCLK=SDATA=SLATCH=SPATTERN=BUSY=ERR_ADDR=0, CMD_READY=1 from the next cycle.
//  Frame word: {pattern, active, addr[4:0]}, sent MSB first: bit6, bit5, then addr[4]..addr[0].
//  FIFO: push on accept; CMD_READY=0 only when DEPTH entries are held. Push and pop in the same cycle are both legal.
//  FSM states:
//   IDLE:  FIFO non-empty -> pop. Legal address -> LOAD. Illegal address -> ERR_ADDR=1 for 1 cycle, no frame, stay IDLE.
//   LOAD:  1 cycle. Shift register <= word, bit counter <= 0, BUSY=1.
//   SHIFT_LO: SCLK=0, SDATA=current bit, for DIV cycles -> SHIFT_HI.
//   SHIFT_HI: SCLK=1, SDATA held, for DIV cycles. bit<6 -> SHIFT_LO (next bit). bit==6 -> LATCH.
//   LATCH: SCLK=0, SDATA=0, SLATCH=1 for DIV cycles -> GAP.
//   GAP:   all serial outputs 0 for DIV cycles -> IDLE. BUSY drops when IDLE is entered.
//  Data changes only while SCLK is low. The CPLD samples SDATA on the SCLK rising edge.
//  SLATCH never overlaps SCLK=1.
//  Frame length: 1 + 16*DIV cycles (33 at DIV=2). Pop-to-first-SCLK-rise: 1 + DIV + 1 cycles.
//  Push into an empty FIFO while IDLE: pop occurs the cycle after the push.
//  Back-to-back frames: the next pop happens in the first IDLE cycle. Frames go out in FIFO order.
//  Reset mid-frame: next cycle all outputs are at reset values and the partial frame is abandoned without SLATCH.
//   The CPLD keeps its previous LED state; the next full frame overwrites the partial shift contents.
//  SPATTERN: counter runs 0..BLINK_DIV-1 while BLINK_EN=1; SPATTERN toggles at wrap (period 2*BLINK_DIV).
//   BLINK_EN=0 -> next cycle SPATTERN=0 and counter=0. SPATTERN is independent of the FSM.
// TESTING
//  T1 reset: hold RESET for 3 cycles, then release -> all outputs 0; CMD_READY=1; BUSY=0.
//  T2 single frame, DIV=2: addr=5, active=1, pattern=0 -> SDATA at SCLK rises is 0,1,0,0,1,0,1; exactly 7 rises;
//     one SLATCH pulse of 2 cycles; BUSY high for exactly 33 cycles.
//  T3 illegal address: addr=19 -> ERR_ADDR pulses for 1 cycle; SCLK and SLATCH stay 0; next legal command is sent normally.
//  T4 back-pressure: CMD_VALID=1 with 6 distinct commands on consecutive cycles -> 5 accepted, CMD_READY=0 on the 6th;
//     after the first frame completes the 6th is accepted; all 6 frames go out in order with no gaps > DIV+1 cycles.
//  T5 reset mid-frame: assert RESET after the 3rd SCLK rise -> next cycle SCLK=SLATCH=BUSY=0; no SLATCH pulse ever
//     appears for that frame; FIFO empty (CMD_READY=1).
//  T6 blink, BLINK_DIV=4: BLINK_EN=1 -> SPATTERN is a square wave with period 8 and 50% duty;
//     BLINK_EN=0 -> SPATTERN=0 next cycle; a frame in flight is unaffected.

Source files
------------

// File: rtl/led_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// led_cmd_sequencer
//
// Host-side controller for the 19-LED CPLD driver. LED commands are queued in
// a small FIFO. Each one goes out as a 7-bit frame {pattern, active, addr[4:0]},
// MSB first, on SCLK/SDATA, and is then latched with an SLATCH pulse. The
// block also generates the shared SPATTERN blink square wave, which runs
// independently of the frame engine.
//
// Ports
//   CLK          in   system clock, rising edge
//   RESET        in   synchronous, active-high reset
//   CMD_VALID    in   command present
//   CMD_READY    out  FIFO not full
//   CMD_ADDR     in   [4:0] LED address
//   CMD_ACTIVE   in   LED steady-on bit
//   CMD_PATTERN  in   LED follows-blink bit
//   BLINK_EN     in   enable for the SPATTERN generator
//   BUSY         out  frame in progress (LOAD through GAP)
//   ERR_ADDR     out  one-cycle pulse when a popped command has an illegal address
//   SCLK         out  serial clock to the CPLD (registered)
//   SDATA        out  serial data (registered)
//   SLATCH       out  latch strobe (registered)
//   SPATTERN     out  blink signal (registered)
//   dbg_state    out  [2:0] current frame FSM state
//
// Handshake: a command transfers on a rising CLK edge where CMD_VALID and
// CMD_READY are both 1. CMD_READY depends only on the FIFO fill level, never
// on CMD_VALID. The host keeps the command stable while CMD_VALID=1 and
// CMD_READY=0.
// -----------------------------------------------------------------------------
module led_cmd_sequencer #(
   parameter int LED_TOT   = 19,
   parameter int DEPTH     = 4,
   parameter int DIV       = 2,
   parameter int BLINK_DIV = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   input  logic [4:0] CMD_ADDR,
   input  logic       CMD_ACTIVE,
   input  logic       CMD_PATTERN,
   input  logic       BLINK_EN,
   output logic       BUSY,
   output logic       ERR_ADDR,
   output logic       SCLK,
   output logic       SDATA,
   output logic       SLATCH,
   output logic       SPATTERN,
   output logic [2:0] dbg_state
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_SHIFT_LO = 3'd2,
      S_SHIFT_HI = 3'd3,
      S_LATCH    = 3'd4,
      S_GAP      = 3'd5
   } state_t;

   // ---------------------------------------------------------------------
   // Command FIFO
   // ---------------------------------------------------------------------
   logic [6:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic [6:0]    head;
   logic          head_legal;

   assign CMD_READY  = (count != (AW+1)'(DEPTH));
   assign push       = CMD_VALID & CMD_READY;
   assign fifo_empty = (count == '0);
   assign head       = mem[rd_ptr];
   assign head_legal = ({27'd0, head[4:0]} < LED_TOT);

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= {CMD_PATTERN, CMD_ACTIVE, CMD_ADDR};
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------------
   state_t        state;
   state_t        state_nxt;
   logic [TW-1:0] tcnt;
   logic          tdone;
   logic [2:0]    bitcnt;
   logic [6:0]    shreg;
   logic          err_set;

   assign tdone     = (tcnt == TW'(DIV - 1));
   assign BUSY      = (state != S_IDLE);
   assign dbg_state = state;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      err_set   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (head_legal) state_nxt = S_LOAD;
               else            err_set   = 1'b1;
            end
         end
         S_LOAD:     state_nxt = S_SHIFT_LO;
         S_SHIFT_LO: if (tdone) state_nxt = S_SHIFT_HI;
         S_SHIFT_HI: if (tdone) state_nxt = (bitcnt == 3'd6) ? S_LATCH : S_SHIFT_LO;
         S_LATCH:    if (tdone) state_nxt = S_GAP;
         S_GAP:      if (tdone) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // The serial pins are registered decodes of the current state, so they
   // trail the state register by one cycle. SCLK and SDATA therefore move on
   // the same edge, and SDATA is stable for DIV cycles before each SCLK rise.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= S_IDLE;
         tcnt     <= '0;
         bitcnt   <= '0;
         shreg    <= '0;
         SCLK     <= 1'b0;
         SDATA    <= 1'b0;
         SLATCH   <= 1'b0;
         ERR_ADDR <= 1'b0;
      end else begin
         state <= state_nxt;

         if ((state_nxt != state) || (state == S_IDLE)) tcnt <= '0;
         else                                            tcnt <= tcnt + TW'(1);

         // The word is captured as it leaves the FIFO, because the head moves
         // on at the same edge. LOAD then sees the word already in place.
         if (pop && head_legal) begin
            shreg  <= head;
            bitcnt <= '0;
         end else if ((state == S_SHIFT_HI) && tdone && (bitcnt != 3'd6)) begin
            shreg  <= {shreg[5:0], 1'b0};
            bitcnt <= bitcnt + 3'd1;
         end

         SCLK     <= (state == S_SHIFT_HI);
         SDATA    <= ((state == S_SHIFT_LO) || (state == S_SHIFT_HI)) & shreg[6];
         SLATCH   <= (state == S_LATCH);
         ERR_ADDR <= err_set;
      end
   end

   // ---------------------------------------------------------------------
   // Blink generator
   // ---------------------------------------------------------------------
   logic [BW-1:0] bcnt;

   always_ff @(posedge CLK) begin
      if (RESET || !BLINK_EN) begin
         bcnt     <= '0;
         SPATTERN <= 1'b0;
      end else if (bcnt == BW'(BLINK_DIV - 1)) begin
         bcnt     <= '0;
         SPATTERN <= ~SPATTERN;
      end else begin
         bcnt     <= bcnt + BW'(1);
      end
   end

endmodule
